// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared control codes and branch-condition helper for pc_seq
package pc_seq_pkg;

    localparam logic [2:0] CC_J    = 3'd0;
    localparam logic [2:0] CC_JZ   = 3'd1;
    localparam logic [2:0] CC_JNZ  = 3'd2;
    localparam logic [2:0] CC_JA   = 3'd3;
    localparam logic [2:0] CC_JAE  = 3'd4;
    localparam logic [2:0] CC_JB   = 3'd5;
    localparam logic [2:0] CC_CALL = 3'd6;
    localparam logic [2:0] CC_RET  = 3'd7;

    localparam int OPC_ALU_BIT = 11;

    // RET is resolved from the stack, so it reports not-taken here
    function automatic logic next_pc_sel(input logic [2:0] cc, input logic z, input logic carry);
        logic taken;
        taken = 1'b0;
        case (cc)
            CC_J:    taken = 1'b1;
            CC_JZ:   taken = z;
            CC_JNZ:  taken = !z;
            CC_JA:   taken = !carry && !z;
            CC_JAE:  taken = !carry;
            CC_JB:   taken = carry;
            CC_CALL: taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - parametrised LIFO return-address stack
module ret_stack #(
    parameter int AW     = 10,
    parameter int SDEPTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic [AW-1:0]             din,
    output logic [AW-1:0]             top,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(SDEPTH):0]   count
);
    localparam int PW = $clog2(SDEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(SDEPTH);

    logic [AW-1:0] r_mem [SDEPTH];
    logic [PW:0]   r_sp;
    logic [PW:0]   w_sp_m1;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_sp == FULL_CNT);
    assign empty     = (r_sp == '0);
    assign count     = r_sp;
    assign w_sp_m1   = r_sp - 1'b1;
    assign top       = r_mem[w_sp_m1[PW-1:0]];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty && !push;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sp <= '0;
        end else if (w_do_push) begin
            r_sp <= r_sp + 1'b1;
        end else if (w_do_pop) begin
            r_sp <= w_sp_m1;
        end
    end

    // Entries carry no reset; only the pointer defines valid contents
    always_ff @(posedge clk) begin
        if (w_do_push && reset) begin
            r_mem[r_sp[PW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program-counter sequencer with return stack
// Optional interrupt entry/return support under PC_SEQ_IRQ_EN.
import pc_seq_pkg::*;

module pc_seq #(
    parameter int            AW      = 10,
    parameter int            SDEPTH  = 8,
    parameter logic [AW-1:0] IRQ_VEC = 'h001
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [15:0]               opcode,
    input  logic [AW-1:0]             target,
    input  logic                      z,
    input  logic                      carry,
    input  logic                      stall,
    input  logic                      clr_err,
    output logic [AW-1:0]             pc,
    output logic                      stack_ovf,
    output logic                      stack_unf,
    output logic [$clog2(SDEPTH):0]   depth
`ifdef PC_SEQ_IRQ_EN
    ,
    input  logic                      irq,
    output logic                      irq_ack,
    output logic                      squash
`endif
);
    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_inc;
    logic [AW-1:0] w_pc_nxt;
    logic [AW-1:0] w_push_data;
    logic [AW-1:0] w_top;
    logic          w_push;
    logic          w_pop;
    logic          w_set_ovf;
    logic          w_set_unf;
    logic          w_full;
    logic          w_empty;
    logic          w_irq_take;
    logic          r_ovf;
    logic          r_unf;

`ifdef PC_SEQ_IRQ_EN
    logic                     r_in_irq;
    logic [$clog2(SDEPTH):0]  r_irq_depth;

    assign w_irq_take = irq && !r_in_irq && !stall && !w_full;
    assign squash     = w_irq_take;
    assign irq_ack    = w_irq_take && reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_irq    <= 1'b0;
            r_irq_depth <= '0;
        end else if (w_irq_take) begin
            r_in_irq    <= 1'b1;
            r_irq_depth <= depth + 1'b1;
        end else if (!stall && w_pop && r_in_irq && (depth == r_irq_depth)) begin
            r_in_irq    <= 1'b0;
        end
    end
`else
    assign w_irq_take = 1'b0;
`endif

    always_comb begin
        w_pc_inc    = r_pc + 1'b1;
        w_pc_nxt    = w_pc_inc;
        w_push_data = w_pc_inc;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_set_ovf   = 1'b0;
        w_set_unf   = 1'b0;
        if (w_irq_take) begin
            // The interrupted instruction is squashed and re-executed on return
            w_pc_nxt    = IRQ_VEC;
            w_push      = 1'b1;
            w_push_data = r_pc;
        end else if (!opcode[OPC_ALU_BIT]) begin
            case (opcode[2:0])
                CC_CALL: begin
                    w_pc_nxt = target;
                    if (w_full) w_set_ovf = 1'b1;
                    else        w_push    = 1'b1;
                end
                CC_RET: begin
                    if (w_empty) begin
                        w_set_unf = 1'b1;
                    end else begin
                        w_pop    = 1'b1;
                        w_pc_nxt = w_top;
                    end
                end
                default: begin
                    if (next_pc_sel(opcode[2:0], z, carry)) w_pc_nxt = target;
                end
            endcase
        end
    end

    ret_stack #(.AW(AW), .SDEPTH(SDEPTH)) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (w_push && !stall),
        .pop   (w_pop && !stall),
        .din   (w_push_data),
        .top   (w_top),
        .full  (w_full),
        .empty (w_empty),
        .count (depth)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= '0;
        end else if (!stall) begin
            r_pc <= w_pc_nxt;
        end
    end

    // An error event in the same cycle as clr_err leaves the flag set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_set_ovf && !stall) r_ovf <= 1'b1;
            else if (clr_err)        r_ovf <= 1'b0;
            if (w_set_unf && !stall) r_unf <= 1'b1;
            else if (clr_err)        r_unf <= 1'b0;
        end
    end

    assign pc        = r_pc;
    assign stack_ovf = r_ovf;
    assign stack_unf = r_unf;

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - directed self-checking bench for pc_seq
module tb_pc_seq;
    localparam logic [15:0] OP_ALU  = 16'h0800;
    localparam logic [15:0] OP_J    = 16'h0000;
    localparam logic [15:0] OP_JZ   = 16'h0001;
    localparam logic [15:0] OP_JNZ  = 16'h0002;
    localparam logic [15:0] OP_JA   = 16'h0003;
    localparam logic [15:0] OP_JAE  = 16'h0004;
    localparam logic [15:0] OP_JB   = 16'h0005;
    localparam logic [15:0] OP_CALL = 16'h0006;
    localparam logic [15:0] OP_RET  = 16'h0007;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] opcode = OP_ALU;
    logic [9:0]  target = '0;
    logic        z = 1'b0;
    logic        carry = 1'b0;
    logic        stall = 1'b0;
    logic        clr_err = 1'b0;
    logic [9:0]  pc;
    logic        stack_ovf;
    logic        stack_unf;
    logic [3:0]  depth;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_seq #(.AW(10), .SDEPTH(8), .IRQ_VEC(10'h001)) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .target    (target),
        .z         (z),
        .carry     (carry),
        .stall     (stall),
        .clr_err   (clr_err),
        .pc        (pc),
        .stack_ovf (stack_ovf),
        .stack_unf (stack_unf),
        .depth     (depth)
    );

    task automatic drive(input logic [15:0] op, input logic [9:0] tg, input logic zz, input logic cc);
        opcode = op;
        target = tg;
        z      = zz;
        carry  = cc;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        drive(OP_ALU, 10'h0, 1'b0, 1'b0);
        tick;
        tick;
        checks++; if (pc !== 10'h000) begin errors++; $display("FAIL reset_pc: got %h expected 000", pc); end
        checks++; if (depth !== 4'd0) begin errors++; $display("FAIL reset_depth: got %0d expected 0", depth); end
        checks++; if (stack_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", stack_ovf); end
        checks++; if (stack_unf !== 1'b0) begin errors++; $display("FAIL reset_unf: got %b expected 0", stack_unf); end
        reset = 1'b1;
    endtask

    task automatic test_alu;
        drive(OP_ALU, 10'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick;
            checks++; if (pc !== 10'(i)) begin errors++; $display("FAIL alu_seq: got %h expected %h", pc, 10'(i)); end
        end
        #2 reset = 1'b0;
        #1;
        checks++; if (pc !== 10'h000) begin errors++; $display("FAIL async_reset: got %h expected 000", pc); end
        tick;
        reset = 1'b1;
    endtask

    task automatic test_ja;
        drive(OP_JA, 10'h040, 1'b0, 1'b0); tick;
        checks++; if (pc !== 10'h040) begin errors++; $display("FAIL ja_taken: got %h expected 040", pc); end
        drive(OP_JA, 10'h040, 1'b1, 1'b0); tick;
        checks++; if (pc !== 10'h041) begin errors++; $display("FAIL ja_z: got %h expected 041", pc); end
        drive(OP_JA, 10'h040, 1'b0, 1'b1); tick;
        checks++; if (pc !== 10'h042) begin errors++; $display("FAIL ja_carry: got %h expected 042", pc); end
        drive(OP_JA, 10'h040, 1'b1, 1'b1); tick;
        checks++; if (pc !== 10'h043) begin errors++; $display("FAIL ja_both: got %h expected 043", pc); end
    endtask

    task automatic test_jae_jb;
        drive(OP_JB, 10'h080, 1'b0, 1'b1); tick;
        checks++; if (pc !== 10'h080) begin errors++; $display("FAIL jb_taken: got %h expected 080", pc); end
        drive(OP_JAE, 10'h080, 1'b0, 1'b1); tick;
        checks++; if (pc !== 10'h081) begin errors++; $display("FAIL jae_fall: got %h expected 081", pc); end
        drive(OP_JAE, 10'h080, 1'b0, 1'b0); tick;
        checks++; if (pc !== 10'h080) begin errors++; $display("FAIL jae_taken: got %h expected 080", pc); end
        drive(OP_JZ, 10'h200, 1'b1, 1'b0); tick;
        checks++; if (pc !== 10'h200) begin errors++; $display("FAIL jz_taken: got %h expected 200", pc); end
        drive(OP_JNZ, 10'h080, 1'b1, 1'b0); tick;
        checks++; if (pc !== 10'h201) begin errors++; $display("FAIL jnz_fall: got %h expected 201", pc); end
        drive(OP_J, 10'h3FF, 1'b0, 1'b0); tick;
        drive(OP_ALU, 10'h000, 1'b0, 1'b0); tick;
        checks++; if (pc !== 10'h000) begin errors++; $display("FAIL pc_wrap: got %h expected 000", pc); end
    endtask

    task automatic test_call_ret;
        drive(OP_J, 10'h005, 1'b0, 1'b0); tick;
        drive(OP_CALL, 10'h100, 1'b0, 1'b0); tick;
        checks++; if (pc !== 10'h100) begin errors++; $display("FAIL call_pc: got %h expected 100", pc); end
        checks++; if (depth !== 4'd1) begin errors++; $display("FAIL call_depth: got %0d expected 1", depth); end
        drive(OP_RET, 10'h000, 1'b0, 1'b0); tick;
        checks++; if (pc !== 10'h006) begin errors++; $display("FAIL ret_pc: got %h expected 006", pc); end
        checks++; if (depth !== 4'd0) begin errors++; $display("FAIL ret_depth: got %0d expected 0", depth); end
    endtask

    task automatic test_nested;
        logic [9:0] ret_addr [9];
        logic [9:0] from_pc;
        logic [9:0] tgt;
        logic [3:0] exp_depth;
        drive(OP_J, 10'h000, 1'b0, 1'b0); tick;
        from_pc = 10'h000;
        for (int k = 0; k < 9; k++) begin
            tgt         = 10'(32 * (k + 1));
            ret_addr[k] = from_pc + 10'd1;
            exp_depth   = (k < 8) ? 4'(k + 1) : 4'd8;
            drive(OP_CALL, tgt, 1'b0, 1'b0); tick;
            checks++; if (pc !== tgt) begin errors++; $display("FAIL nest_call_pc[%0d]: got %h expected %h", k, pc, tgt); end
            checks++; if (depth !== exp_depth) begin errors++; $display("FAIL nest_depth[%0d]: got %0d expected %0d", k, depth, exp_depth); end
            from_pc = tgt;
        end
        checks++; if (stack_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", stack_ovf); end
        for (int r = 7; r >= 0; r--) begin
            drive(OP_RET, 10'h000, 1'b0, 1'b0); tick;
            checks++; if (pc !== ret_addr[r]) begin errors++; $display("FAIL unwind_pc[%0d]: got %h expected %h", r, pc, ret_addr[r]); end
            checks++; if (depth !== 4'(r)) begin errors++; $display("FAIL unwind_depth[%0d]: got %0d expected %0d", r, depth, r); end
        end
        drive(OP_RET, 10'h000, 1'b0, 1'b0); tick;
        checks++; if (pc !== 10'h002) begin errors++; $display("FAIL unf_pc: got %h expected 002", pc); end
        checks++; if (stack_unf !== 1'b1) begin errors++; $display("FAIL unf_set: got %b expected 1", stack_unf); end
        checks++; if (depth !== 4'd0) begin errors++; $display("FAIL unf_depth: got %0d expected 0", depth); end
        clr_err = 1'b1;
        drive(OP_RET, 10'h000, 1'b0, 1'b0); tick;
        checks++; if (stack_unf !== 1'b1) begin errors++; $display("FAIL set_wins_unf: got %b expected 1", stack_unf); end
        checks++; if (stack_ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b expected 0", stack_ovf); end
        drive(OP_ALU, 10'h000, 1'b0, 1'b0); tick;
        clr_err = 1'b0;
        checks++; if (stack_unf !== 1'b0) begin errors++; $display("FAIL clr_unf: got %b expected 0", stack_unf); end
        checks++; if (pc !== 10'h004) begin errors++; $display("FAIL clr_pc: got %h expected 004", pc); end
    endtask

    task automatic test_stall;
        drive(OP_J, 10'h010, 1'b0, 1'b0); tick;
        stall = 1'b1;
        drive(OP_CALL, 10'h100, 1'b0, 1'b0); tick;
        checks++; if (pc !== 10'h010) begin errors++; $display("FAIL stall_pc: got %h expected 010", pc); end
        checks++; if (depth !== 4'd0) begin errors++; $display("FAIL stall_depth: got %0d expected 0", depth); end
        drive(OP_RET, 10'h000, 1'b0, 1'b0); tick;
        checks++; if (stack_unf !== 1'b0) begin errors++; $display("FAIL stall_no_unf: got %b expected 0", stack_unf); end
        stall = 1'b0;
        tick;
        checks++; if (stack_unf !== 1'b1) begin errors++; $display("FAIL unstall_unf: got %b expected 1", stack_unf); end
        checks++; if (pc !== 10'h011) begin errors++; $display("FAIL unstall_pc: got %h expected 011", pc); end
        stall   = 1'b1;
        clr_err = 1'b1;
        drive(OP_ALU, 10'h000, 1'b0, 1'b0); tick;
        stall   = 1'b0;
        clr_err = 1'b0;
        checks++; if (stack_unf !== 1'b0) begin errors++; $display("FAIL stall_clr: got %b expected 0", stack_unf); end
        checks++; if (pc !== 10'h011) begin errors++; $display("FAIL stall_clr_pc: got %h expected 011", pc); end
        drive(OP_CALL, 10'h100, 1'b0, 1'b0); tick;
        checks++; if (pc !== 10'h100) begin errors++; $display("FAIL post_stall_call: got %h expected 100", pc); end
        checks++; if (depth !== 4'd1) begin errors++; $display("FAIL post_stall_depth: got %0d expected 1", depth); end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_ja;
        test_jae_jb;
        test_call_ret;
        test_nested;
        test_stall;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
